// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller for common-anode digits
//
// Walks DIGITS time-multiplexed digits, one slot of 2**DIVBITS clocks each.
// The first BLANK clocks of every slot are blanked so the previous digit's
// pattern never ghosts onto the next anode. Characters are held in a small
// buffer written through a valid/ready port and presented one at a time to
// an external ASCII-to-segment lookup.
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   reset_n   in   asynchronous active-low reset
//   en        in   display enable; low blanks every digit
//   wr_valid  in   buffer write request
//   wr_ready  out  write accepted when wr_valid & wr_ready at a rising edge
//   wr_index  in   buffer entry to write
//   wr_char   in   ASCII code to store
//   char      out  character presented to the lookup
//   seg_in    in   registered lookup pattern (updates on the falling edge)
//   seg       out  active-low segments, bit 7 = decimal point
//   an        out  active-low anode selects, bit i = digit i

module seg_scan_ctrl #(
  parameter int IDXW    = 2,
  parameter int DIVBITS = 16,
  parameter int BLANK   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDXW-1:0]       wr_index,
  input  logic [6:0]            wr_char,
  output logic [6:0]            char,
  input  logic [7:0]            seg_in,
  output logic [7:0]            seg,
  output logic [(2**IDXW)-1:0]  an
);

  localparam int DIGITS = 2**IDXW;

  localparam logic [DIVBITS-1:0] BLANK_V  = DIVBITS'(BLANK);
  localparam logic [6:0]         SPACE    = 7'd32;
  localparam logic [7:0]         SEG_OFF  = 8'hFF;
  localparam logic [DIGITS-1:0]  AN_OFF   = '1;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IDXW-1:0]     cur, cur_nxt;
  logic [IDXW-1:0]     init_cnt, init_cnt_nxt;
  logic [DIVBITS-1:0]  div, div_nxt, div_inc;
  logic [7:0]          seg_nxt;
  logic [DIGITS-1:0]   an_nxt;
  logic [6:0]          char_nxt;

  logic [6:0]          char_buf [DIGITS];
  logic                buf_we;
  logic [IDXW-1:0]     buf_addr;
  logic [6:0]          buf_data;

  // The port is closed only while INIT owns the buffer write path.
  assign wr_ready = (state != S_INIT);

  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    div_nxt      = div;
    init_cnt_nxt = init_cnt;
    seg_nxt      = seg;
    an_nxt       = an;
    char_nxt     = char;
    buf_we       = 1'b0;
    buf_addr     = wr_index;
    buf_data     = wr_char;
    div_inc      = div + DIVBITS'(1);

    case (state)
      S_INIT: begin
        // Clear one entry per clock; the port is closed so no write competes.
        buf_we       = 1'b1;
        buf_addr     = init_cnt;
        buf_data     = SPACE;
        init_cnt_nxt = init_cnt + IDXW'(1);
        if (init_cnt == {IDXW{1'b1}}) begin
          state_nxt = en ? S_RUN : S_OFF;
          cur_nxt   = '0;
          div_nxt   = '0;
        end
      end

      S_RUN: begin
        char_nxt = char_buf[cur];
        buf_we   = wr_valid;
        if (!en) begin
          state_nxt = S_OFF;
          div_nxt   = '0;
          an_nxt    = AN_OFF;
          seg_nxt   = SEG_OFF;
        end else begin
          div_nxt = div_inc;
          if (div == {DIVBITS{1'b1}}) begin
            cur_nxt = cur + IDXW'(1);
          end
          // Outputs follow the slot position the divider is moving to, so the
          // anode drops exactly on the capture edge and never during blank.
          if (div_inc < BLANK_V) begin
            an_nxt  = AN_OFF;
            seg_nxt = SEG_OFF;
          end else if (div_inc == BLANK_V) begin
            // BLANK >= 3 keeps this edge away from a wrap, so cur is the
            // digit whose character has been in char for two clocks.
            seg_nxt = seg_in;
            an_nxt  = ~(DIGITS'(1) << cur);
          end
        end
      end

      S_OFF: begin
        char_nxt = char_buf[cur];
        buf_we   = wr_valid;
        div_nxt  = '0;
        an_nxt   = AN_OFF;
        seg_nxt  = SEG_OFF;
        // Re-entering RUN with div at 0 restarts cur's slot from its blank phase.
        if (en) begin
          state_nxt = S_RUN;
        end
      end

      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_INIT;
      cur      <= '0;
      init_cnt <= '0;
      div      <= '0;
      seg      <= SEG_OFF;
      an       <= AN_OFF;
      char     <= SPACE;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      init_cnt <= init_cnt_nxt;
      div      <= div_nxt;
      seg      <= seg_nxt;
      an       <= an_nxt;
      char     <= char_nxt;
    end
  end

  // Buffer has no reset: INIT rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      char_buf[buf_addr] <= buf_data;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl against a slot-level model

module tb_seg_scan_ctrl;

  localparam int BLANK = 3;
  localparam int SLOT  = 16;
  localparam int NDIG  = 4;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_index;
  logic [6:0] wr_char;
  logic [6:0] char;
  logic [7:0] seg_in;
  logic [7:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.IDXW(2), .DIVBITS(4), .BLANK(BLANK)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_index (wr_index),
    .wr_char  (wr_char),
    .char     (char),
    .seg_in   (seg_in),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Seven-segment lookup: standard active-low digit patterns, space blank,
  // anything else returns decimal point lit with an arbitrary body.
  function automatic logic [7:0] lut(input logic [6:0] c);
    case (c)
      7'd32:   return 8'hFF;
      7'd48:   return 8'hC0;
      7'd49:   return 8'hF9;
      7'd50:   return 8'hA4;
      7'd51:   return 8'hB0;
      7'd52:   return 8'h99;
      7'd53:   return 8'h92;
      7'd54:   return 8'h82;
      7'd55:   return 8'hF8;
      7'd56:   return 8'h80;
      7'd57:   return 8'h90;
      default: return {1'b0, c};
    endcase
  endfunction

  initial seg_in = 8'hFF;
  always @(negedge clk) seg_in <= lut(char);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Slot-level model: mode, position in slot, digit, buffer history.
  int         m_mode;   // 0 init, 1 run, 2 off
  int         m_icnt;
  int         m_pos;
  int         m_cur;
  logic [6:0] m_buf [NDIG];
  logic [6:0] snap1 [NDIG];
  logic [6:0] snap2 [NDIG];
  logic [6:0] m_char;
  logic [7:0] m_shown;

  task automatic model_reset();
    m_mode = 0;
    m_icnt = 0;
    m_pos  = 0;
    m_cur  = 0;
    m_char = 7'd32;
  endtask

  task automatic model_edge();
    int old_mode;
    int old_cur;
    if (!reset_n) return;
    snap2 = snap1;      // buffer as it stood two edges ago
    snap1 = m_buf;      // buffer as it stood one edge ago
    old_mode = m_mode;
    old_cur  = m_cur;
    if (old_mode != 0) m_char = snap1[old_cur];
    case (old_mode)
      0: begin
        m_buf[m_icnt] = 7'd32;
        if (m_icnt == NDIG - 1) begin
          m_mode = en ? 1 : 2;
          m_pos  = 0;
          m_cur  = 0;
        end
        m_icnt = (m_icnt + 1) % NDIG;
      end
      1: begin
        if (!en) begin
          m_mode = 2;
          m_pos  = 0;
        end else begin
          m_pos = (m_pos + 1) % SLOT;
          if (m_pos == 0) m_cur = (m_cur + 1) % NDIG;
          // A character shows if it was in the buffer two edges before capture.
          if (m_pos == BLANK) m_shown = lut(snap2[m_cur]);
        end
      end
      default: begin
        m_pos = 0;
        if (en) m_mode = 1;
      end
    endcase
    if (old_mode != 0 && wr_valid) m_buf[wr_index] = wr_char;
  endtask

  task automatic compare();
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    exp_an  = 4'hF;
    exp_seg = 8'hFF;
    if (m_mode == 1 && m_pos >= BLANK) begin
      exp_an[m_cur] = 1'b0;
      exp_seg       = m_shown;
    end
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("char", 32'(char), 32'(m_char));
    check("wr_ready", 32'(wr_ready), 32'(m_mode != 0));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write(input int idx, input logic [6:0] c);
    logic [1:0] ix;
    ix       = idx[1:0];
    wr_valid = 1'b1;
    wr_index = ix;
    wr_char  = c;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic wait_show(input int d);
    int n;
    n = 0;
    while (!(m_mode == 1 && m_pos >= BLANK + 1 && m_pos <= 8 && m_cur == d) && n < 300) begin
      cyc();
      n++;
    end
    check("wait_show", 32'(n < 300), 32'd1);
  endtask

  logic [6:0] pick [8];

  initial begin
    pick[0] = 7'd32; pick[1] = 7'd48; pick[2] = 7'd53; pick[3] = 7'd56;
    pick[4] = 7'd57; pick[5] = 7'd35; pick[6] = 7'd65; pick[7] = 7'd50;

    en       = 1'b1;
    wr_valid = 1'b0;
    wr_index = 2'd0;
    wr_char  = 7'd0;
    model_reset();
    for (int k = 0; k < NDIG; k++) begin
      m_buf[k] = 7'd32;
      snap1[k] = 7'd32;
      snap2[k] = 7'd32;
    end
    m_shown  = 8'hFF;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_char", 32'(char), 32'd32);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    run(3);
    reset_n = 1'b1;

    // INIT, then first slot of digit 0 showing a space
    run(10);

    // Digits 0..3 across a full frame
    write(0, 7'd48);
    write(1, 7'd49);
    write(2, 7'd50);
    write(3, 7'd51);
    run(80);

    // Overwrite digit 0 while it shows
    wait_show(0);
    write(0, 7'd56);
    run(70);

    // Disable mid-show of digit 2, write while off, re-enable
    wait_show(2);
    en = 1'b0;
    run(3);
    write(1, 7'd55);
    run(2);
    en = 1'b1;
    run(40);

    // Undefined code lights the decimal point
    write(3, 7'd35);
    run(70);

    // Randomized traffic with occasional enable toggles
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(63) == 0) en = ~en;
      if ($urandom_range(3) == 0) begin
        wr_valid = 1'b1;
        wr_index = 2'($urandom_range(3));
        wr_char  = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : pick[$urandom_range(7)];
      end else begin
        wr_valid = 1'b0;
      end
      cyc();
    end
    wr_valid = 1'b0;
    en       = 1'b1;
    run(40);

    // Reset mid-show: outputs drop without a clock edge, buffer re-cleared
    write(1, 7'd52);
    wait_show(1);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    check("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    check("mid_rst_char", 32'(char), 32'd32);
    run(2);
    reset_n = 1'b1;
    run(90);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexed seven-segment display controller that sequences the shared ASCII-to-segment lookup across `DIGITS` time-multiplexed digits. Holds a small character buffer written through a valid/ready port, walks the digits at a divided refresh rate, and presents one character at a time to the lookup. Captures the lookup's registered segment pattern and drives segment and anode lines with ghost-blanking at every digit change. Sits between the memory-mapped display device and the board's common-anode LED pins.

## Interface
- `IDXW`, 2: digit index width; `DIGITS = 2**IDXW`.
- `DIVBITS`, 16: slot length is `2**DIVBITS` clocks per digit.
- `BLANK`, 4: blanked clocks at the start of each slot; legal range 3 .. `2**DIVBITS - 1`.

- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  display enable; low turns all digits off.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready` at a rising edge.
- `wr_index`  in  IDXW  target buffer entry.
- `wr_char`  in  7  ASCII code to store.
- `char`  out  7  character presented to the lookup.
- `seg_in`  in  8  pattern returned by the lookup (updated on falling edge of `clk`).
- `seg`  out  8  active-low segments, bit 7 = decimal point.
- `an`  out  DIGITS  active-low anode selects, bit i = digit i.

## Operation
- States: INIT, RUN, OFF. Registers: buffer `buf[DIGITS]` (7 bits each), `cur` (IDXW), `div` (DIVBITS), `seg`, `an`, `char`, INIT counter.
- INIT: writes 7'd32 (space) into `buf[k]` for k = 0..DIGITS-1, one entry per clock; `wr_ready`=0. After entry DIGITS-1, go to RUN if `en`, else OFF; `cur`=0, `div`=0.
- RUN: `div` increments every clock, wrapping at all-ones. On wrap, `cur` increments modulo DIGITS (DIGITS-1 -> 0).
  - Blank phase (`div` < BLANK): `an` all ones, `seg` = 8'hFF.
  - Show phase (`div` >= BLANK): `an` = all ones except bit `cur` = 0; `seg` holds the captured pattern.
  - `seg` captures `seg_in` on the edge where `div` goes BLANK-1 -> BLANK.
- `char` register samples `buf[cur]` every rising edge in RUN/OFF; lookup output settles by the following falling edge, so BLANK >= 3 guarantees a fresh capture.
- OFF (`en`=0 in RUN): `an` all ones, `seg` 8'hFF, `div` held at 0, `cur` preserved. `en`=1 returns to RUN, restarting the slot of `cur` with its blank phase.
- Writes: `wr_ready`=1 in RUN and OFF. An accepted write updates `buf[wr_index]` at that edge. A write to the displayed digit during its show phase appears from that digit's next slot; during blank, it appears if accepted at least 2 clocks before the capture edge.
- Undefined codes: lookup yields bit 7 = 0 with X elsewhere; passed through unmodified (decimal point lit).
- At most one anode low at any time; never low during blank phase.

## Timing
- Reset values (async): `an` all ones, `seg` 8'hFF, `char` 7'd32, `wr_ready` 0, state INIT, `cur` 0, `div` 0.
- After `reset_n` rises: DIGITS clocks of INIT, then `wr_ready`=1. First anode (digit 0) goes low BLANK clocks after entering RUN.
- Refresh period per full frame: DIGITS * 2**DIVBITS clocks.
- `en` falling: `an`/`seg` off at the next edge. `en` rising: BLANK-clock blank, then show.
- `reset_n` low mid-operation: outputs go to reset values immediately; buffer contents are re-cleared by INIT.

## Test plan
Bench parameters: IDXW=2, DIVBITS=4, BLANK=3.
- Release reset, `en`=1 -> `wr_ready`=0 for 4 clocks, `char`=32; `an`=4'b1111 for 3 clocks, then `an`=4'b1110, `seg`=8'hFF.
- Write '0','1','2','3' to entries 0..3 -> over 64 clocks `an` cycles 1110,1101,1011,0111 with `seg` C0,F9,A4,B0; 3 blank clocks at each slot start; never two anodes low.
- Write '8' to entry 0 while digit 0 shows -> current slot unchanged; next digit-0 slot shows `seg`=8'b10000000.
- Drop `en` mid-show of digit 2 -> next edge `an`=1111, `seg`=FF; a write while off is accepted. Raise `en` -> 3 blank clocks, then `an`=1011.
- Write '#' (35) -> in that digit's show phase `seg[7]`=0.
- Assert `reset_n` mid-show -> `an`=1111, `seg`=FF, `wr_ready`=0 without a clock edge; after release, all digits show spaces.
